// File: rtl/monobit_stream_if.sv
// Stream/result bundle for monobit_stream. The run-count outputs exist only
// when MONOBIT_STREAM_RUNS_EN is defined.
interface monobit_stream_if #(
  parameter int LOG2N = 7,
  parameter int FAILW = 8
);
  logic             start;
  logic             continuous;
  logic             clear;
  logic             bit_in;
  logic             bit_valid;
  logic             ready;
  logic             result_valid;
  logic             pass;
  logic [LOG2N:0]   sum_abs;
  logic [LOG2N:0]   ones_cnt;
  logic [FAILW-1:0] fail_cnt;
  logic             busy;
`ifdef MONOBIT_STREAM_RUNS_EN
  logic [LOG2N:0]   run_cnt;
  logic             runs_ok;

  modport master (
    output start, continuous, clear, bit_in, bit_valid,
    input  ready, result_valid, pass, sum_abs, ones_cnt, fail_cnt, busy, run_cnt, runs_ok
  );
  modport slave (
    input  start, continuous, clear, bit_in, bit_valid,
    output ready, result_valid, pass, sum_abs, ones_cnt, fail_cnt, busy, run_cnt, runs_ok
  );
`else
  modport master (
    output start, continuous, clear, bit_in, bit_valid,
    input  ready, result_valid, pass, sum_abs, ones_cnt, fail_cnt, busy
  );
  modport slave (
    input  start, continuous, clear, bit_in, bit_valid,
    output ready, result_valid, pass, sum_abs, ones_cnt, fail_cnt, busy
  );
`endif
endinterface

// File: rtl/monobit_stream.sv
// Streaming monobit (frequency) tester over windows of 2**LOG2N bits.
// Optional run-count prerequisite outputs are enabled by MONOBIT_STREAM_RUNS_EN.
module monobit_stream #(
  parameter int LOG2N  = 7,
  parameter int THRESH = 29,
  parameter int FAILW  = 8
) (
  input logic            clk,
  input logic            rst_n,
  monobit_stream_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, REPORT = 2'd2} state_t;

  localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};
  localparam logic [LOG2N:0]   HALF_N   = {2'b01, {(LOG2N-1){1'b0}}};
  localparam logic [LOG2N+1:0] N_EXT    = {2'b01, {LOG2N{1'b0}}};
  localparam logic [LOG2N+1:0] THR_EXT  = (LOG2N+2)'(THRESH);
  localparam logic [FAILW-1:0] FAIL_MAX = {FAILW{1'b1}};

  state_t             state_r, state_s;
  logic               mode_r, ready_r, busy_r, result_valid_r, pass_r;
  logic [LOG2N:0]     sum_abs_r, ones_cnt_r, ones_acc_r;
  logic [FAILW-1:0]   fail_cnt_r;
  logic [LOG2N-1:0]   bit_cnt_r;
  logic               accept_s, last_s, pass_s;
  logic [LOG2N:0]     ones_next_s, sum_abs_s;
  logic [LOG2N+1:0]   twice_s, diff_s;

  // Accept qualification and end-of-window statistics from the final count.
  always_comb begin
    accept_s    = bus.bit_valid && ready_r && !bus.clear;
    last_s      = accept_s && (bit_cnt_r == LAST_IDX);
    ones_next_s = ones_acc_r + {{LOG2N{1'b0}}, bus.bit_in};
    twice_s     = {ones_next_s, 1'b0};
    if (ones_next_s >= HALF_N) begin
      diff_s = twice_s - N_EXT;
    end else begin
      diff_s = N_EXT - twice_s;
    end
    sum_abs_s = diff_s[LOG2N:0];
    pass_s    = (diff_s <= THR_EXT);
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_s = state_r;
    if (bus.clear) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = bus.start ? COLLECT : IDLE;
        COLLECT: state_s = last_s ? REPORT : COLLECT;
        REPORT:  state_s = mode_r ? COLLECT : IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register with registered ready/busy decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == COLLECT);
      busy_r  <= (state_s != IDLE);
    end
  end

  // Accumulators and results; results land on the edge accepting bit N so
  // result_valid is high throughout the REPORT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r         <= 1'b0;
      result_valid_r <= 1'b0;
      pass_r         <= 1'b0;
      sum_abs_r      <= '0;
      ones_cnt_r     <= '0;
      ones_acc_r     <= '0;
      fail_cnt_r     <= '0;
      bit_cnt_r      <= '0;
    end else if (bus.clear) begin
      mode_r         <= 1'b0;
      result_valid_r <= 1'b0;
      pass_r         <= 1'b0;
      sum_abs_r      <= '0;
      ones_cnt_r     <= '0;
      ones_acc_r     <= '0;
      fail_cnt_r     <= '0;
      bit_cnt_r      <= '0;
    end else begin
      result_valid_r <= 1'b0;
      if (state_r == IDLE && bus.start) begin
        mode_r <= bus.continuous;
      end
      if (accept_s) begin
        bit_cnt_r <= bit_cnt_r + {{(LOG2N-1){1'b0}}, 1'b1};
        if (last_s) begin
          result_valid_r <= 1'b1;
          ones_cnt_r     <= ones_next_s;
          sum_abs_r      <= sum_abs_s;
          pass_r         <= pass_s;
          ones_acc_r     <= '0;
          if (!pass_s && fail_cnt_r != FAIL_MAX) begin
            fail_cnt_r <= fail_cnt_r + {{(FAILW-1){1'b0}}, 1'b1};
          end
        end else begin
          ones_acc_r <= ones_next_s;
        end
      end
    end
  end

  assign bus.ready        = ready_r;
  assign bus.busy         = busy_r;
  assign bus.result_valid = result_valid_r;
  assign bus.pass         = pass_r;
  assign bus.sum_abs      = sum_abs_r;
  assign bus.ones_cnt     = ones_cnt_r;
  assign bus.fail_cnt     = fail_cnt_r;

`ifdef MONOBIT_STREAM_RUNS_EN
  localparam int             RUN_SH    = LOG2N - (LOG2N / 2 + 1);
  localparam logic [LOG2N:0] RUN_BOUND = {{LOG2N{1'b0}}, 1'b1} << RUN_SH;

  logic           prev_r, runs_ok_r;
  logic [LOG2N:0] runs_acc_r, run_cnt_r, runs_next_s, dev_s;
  logic           runs_ok_s;

  // Running run count (first bit of a window opens run 1) and balance check.
  always_comb begin
    if (bit_cnt_r == {LOG2N{1'b0}}) begin
      runs_next_s = {{LOG2N{1'b0}}, 1'b1};
    end else begin
      runs_next_s = runs_acc_r + {{LOG2N{1'b0}}, (bus.bit_in ^ prev_r)};
    end
    if (ones_next_s >= HALF_N) begin
      dev_s = ones_next_s - HALF_N;
    end else begin
      dev_s = HALF_N - ones_next_s;
    end
    runs_ok_s = (dev_s < RUN_BOUND);
  end

  // Run-count registers, cleared at each window start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r     <= 1'b0;
      runs_acc_r <= '0;
      run_cnt_r  <= '0;
      runs_ok_r  <= 1'b0;
    end else if (bus.clear) begin
      prev_r     <= 1'b0;
      runs_acc_r <= '0;
      run_cnt_r  <= '0;
      runs_ok_r  <= 1'b0;
    end else if (accept_s) begin
      if (last_s) begin
        prev_r     <= 1'b0;
        runs_acc_r <= '0;
        run_cnt_r  <= runs_next_s;
        runs_ok_r  <= runs_ok_s;
      end else begin
        prev_r     <= bus.bit_in;
        runs_acc_r <= runs_next_s;
      end
    end
  end

  assign bus.run_cnt = run_cnt_r;
  assign bus.runs_ok = runs_ok_r;
`endif
endmodule

// File: tb/tb_monobit_stream.sv
// Directed self-checking bench for monobit_stream (LOG2N=7, THRESH=29), plus a
// FAILW=2 instance for the saturation scenario.
module tb_monobit_stream;
  localparam int N = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   passed = 0;
  int   rv_cnt = 0;

  always #5 clk = ~clk;

  monobit_stream_if #(.LOG2N(7), .FAILW(8)) bus ();
  monobit_stream_if #(.LOG2N(7), .FAILW(2)) sbus ();

  monobit_stream #(.LOG2N(7), .THRESH(29), .FAILW(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  monobit_stream #(.LOG2N(7), .THRESH(29), .FAILW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sbus)
  );

  always @(negedge clk) if (bus.result_valid === 1'b1) rv_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic cont);
    bus.start = 1'b1; bus.continuous = cont;
    step();
    bus.start = 1'b0; bus.continuous = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.bit_valid = 1'b1; bus.bit_in = b;
    step();
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
  endtask

  task automatic test_reset();
    int base;
    #2 rst_n = 1'b0;
    repeat (3) step();
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.ready); else passed++;
    checks++; if (bus.result_valid !== 1'b0) $display("FAIL rst_rv: got %b want 0", bus.result_valid); else passed++;
    checks++; if (bus.pass !== 1'b0) $display("FAIL rst_pass: got %b want 0", bus.pass); else passed++;
    checks++; if (bus.sum_abs !== 8'd0) $display("FAIL rst_sum: got %0d want 0", bus.sum_abs); else passed++;
    checks++; if (bus.ones_cnt !== 8'd0) $display("FAIL rst_ones: got %0d want 0", bus.ones_cnt); else passed++;
    checks++; if (bus.fail_cnt !== 8'd0) $display("FAIL rst_fail: got %0d want 0", bus.fail_cnt); else passed++;
    checks++; if (sbus.fail_cnt !== 2'd0) $display("FAIL rst_sat_fail: got %0d want 0", sbus.fail_cnt); else passed++;
    rst_n = 1'b1;
    step();
    base = rv_cnt;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    step();
    checks++; if (bus.ones_cnt !== 8'd0) $display("FAIL idle_ones: got %0d want 0", bus.ones_cnt); else passed++;
    checks++; if (rv_cnt !== base) $display("FAIL idle_rv: got %0d pulses want 0", rv_cnt - base); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_balanced();
    int base;
    base = rv_cnt;
    pulse_start(1'b0);
    checks++; if (bus.busy !== 1'b1) $display("FAIL bal_busy: got %b want 1", bus.busy); else passed++;
    checks++; if (bus.ready !== 1'b1) $display("FAIL bal_ready: got %b want 1", bus.ready); else passed++;
    for (int i = 0; i < N - 1; i++) send_bit((i % 2) == 0);
    checks++; if (bus.result_valid !== 1'b0) $display("FAIL bal_early_rv: got %b want 0", bus.result_valid); else passed++;
    send_bit(1'b0);
    checks++; if (bus.result_valid !== 1'b1) $display("FAIL bal_rv: got %b want 1", bus.result_valid); else passed++;
    checks++; if (bus.ones_cnt !== 8'd64) $display("FAIL bal_ones: got %0d want 64", bus.ones_cnt); else passed++;
    checks++; if (bus.sum_abs !== 8'd0) $display("FAIL bal_sum: got %0d want 0", bus.sum_abs); else passed++;
    checks++; if (bus.pass !== 1'b1) $display("FAIL bal_pass: got %b want 1", bus.pass); else passed++;
    checks++; if (bus.fail_cnt !== 8'd0) $display("FAIL bal_fail: got %0d want 0", bus.fail_cnt); else passed++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL bal_ready_rep: got %b want 0", bus.ready); else passed++;
`ifdef MONOBIT_STREAM_RUNS_EN
    checks++; if (bus.run_cnt !== 8'd128) $display("FAIL bal_runs: got %0d want 128", bus.run_cnt); else passed++;
    checks++; if (bus.runs_ok !== 1'b1) $display("FAIL bal_runs_ok: got %b want 1", bus.runs_ok); else passed++;
`endif
    step();
    checks++; if (bus.result_valid !== 1'b0) $display("FAIL bal_rv_off: got %b want 0", bus.result_valid); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL bal_idle: got %b want 0", bus.busy); else passed++;
    checks++; if (rv_cnt - base !== 1) $display("FAIL bal_pulses: got %0d want 1", rv_cnt - base); else passed++;
  endtask

  task automatic single_window(input int ones, input int exp_sum, input logic exp_pass, input int exp_fail);
    pulse_start(1'b0);
    for (int i = 0; i < N; i++) send_bit(i < ones);
    checks++; if (bus.result_valid !== 1'b1) $display("FAIL thr%0d_rv: got %b want 1", ones, bus.result_valid); else passed++;
    checks++; if (bus.ones_cnt !== 8'(ones)) $display("FAIL thr%0d_ones: got %0d want %0d", ones, bus.ones_cnt, ones); else passed++;
    checks++; if (bus.sum_abs !== 8'(exp_sum)) $display("FAIL thr%0d_sum: got %0d want %0d", ones, bus.sum_abs, exp_sum); else passed++;
    checks++; if (bus.pass !== exp_pass) $display("FAIL thr%0d_pass: got %b want %b", ones, bus.pass, exp_pass); else passed++;
    checks++; if (bus.fail_cnt !== 8'(exp_fail)) $display("FAIL thr%0d_fail: got %0d want %0d", ones, bus.fail_cnt, exp_fail); else passed++;
`ifdef MONOBIT_STREAM_RUNS_EN
    checks++; if (bus.run_cnt !== 8'd2) $display("FAIL thr%0d_runs: got %0d want 2", ones, bus.run_cnt); else passed++;
    checks++; if (bus.runs_ok !== 1'b0) $display("FAIL thr%0d_runs_ok: got %b want 0", ones, bus.runs_ok); else passed++;
`endif
    step();
  endtask

  task automatic test_threshold();
    single_window(79, 30, 1'b0, 1);
    single_window(80, 32, 1'b0, 2);
    single_window(78, 28, 1'b1, 2);
  endtask

  task automatic test_clear_mid();
    int base;
    pulse_start(1'b0);
    for (int i = 0; i < 50; i++) send_bit(1'b1);
    checks++; if (bus.sum_abs !== 8'd28) $display("FAIL hold_sum: got %0d want 28", bus.sum_abs); else passed++;
    base = rv_cnt;
    bus.clear = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    step();
    bus.clear = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    checks++; if (bus.busy !== 1'b0) $display("FAIL clr_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL clr_ready: got %b want 0", bus.ready); else passed++;
    checks++; if (bus.result_valid !== 1'b0) $display("FAIL clr_rv: got %b want 0", bus.result_valid); else passed++;
    checks++; if (bus.ones_cnt !== 8'd0) $display("FAIL clr_ones: got %0d want 0", bus.ones_cnt); else passed++;
    checks++; if (bus.sum_abs !== 8'd0) $display("FAIL clr_sum: got %0d want 0", bus.sum_abs); else passed++;
    checks++; if (bus.pass !== 1'b0) $display("FAIL clr_pass: got %b want 0", bus.pass); else passed++;
    checks++; if (bus.fail_cnt !== 8'd0) $display("FAIL clr_fail: got %0d want 0", bus.fail_cnt); else passed++;
    bus.start = 1'b1; bus.clear = 1'b1;
    step();
    bus.start = 1'b0; bus.clear = 1'b0;
    checks++; if (bus.busy !== 1'b0) $display("FAIL clr_start_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (rv_cnt !== base) $display("FAIL clr_pulses: got %0d want 0", rv_cnt - base); else passed++;
    pulse_start(1'b0);
    for (int i = 0; i < N; i++) send_bit(1'b1);
    checks++; if (bus.ones_cnt !== 8'd128) $display("FAIL clr_restart_ones: got %0d want 128", bus.ones_cnt); else passed++;
    checks++; if (bus.sum_abs !== 8'd128) $display("FAIL clr_restart_sum: got %0d want 128", bus.sum_abs); else passed++;
    checks++; if (bus.fail_cnt !== 8'd1) $display("FAIL clr_restart_fail: got %0d want 1", bus.fail_cnt); else passed++;
    step();
  endtask

  task automatic test_continuous_gaps();
    int base;
    int cyc;
    int acc;
    logic v;
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    checks++; if (bus.fail_cnt !== 8'd0) $display("FAIL cont_pre_fail: got %0d want 0", bus.fail_cnt); else passed++;
    base = rv_cnt;
    cyc = 0;
    pulse_start(1'b1);
    for (int w = 0; w < 3; w++) begin
      acc = 0;
      while (acc < N) begin
        v = ((cyc % 5) != 3);
        bus.bit_valid = v; bus.bit_in = 1'b0;
        step();
        if (v) acc++;
        cyc++;
      end
      bus.bit_valid = 1'b0;
      checks++; if (bus.result_valid !== 1'b1) $display("FAIL cont%0d_rv: got %b want 1", w, bus.result_valid); else passed++;
      checks++; if (bus.sum_abs !== 8'd128) $display("FAIL cont%0d_sum: got %0d want 128", w, bus.sum_abs); else passed++;
      checks++; if (bus.pass !== 1'b0) $display("FAIL cont%0d_pass: got %b want 0", w, bus.pass); else passed++;
      checks++; if (bus.fail_cnt !== 8'(w + 1)) $display("FAIL cont%0d_fail: got %0d want %0d", w, bus.fail_cnt, w + 1); else passed++;
      // A one offered during REPORT must not leak into the next window.
      bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
      step();
      bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
      checks++; if (bus.result_valid !== 1'b0) $display("FAIL cont%0d_rv_off: got %b want 0", w, bus.result_valid); else passed++;
      checks++; if (bus.ready !== 1'b1) $display("FAIL cont%0d_rearm: got %b want 1", w, bus.ready); else passed++;
    end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    checks++; if (rv_cnt - base !== 3) $display("FAIL cont_pulses: got %0d want 3", rv_cnt - base); else passed++;
  endtask

  task automatic test_saturation();
    int exp;
    sbus.start = 1'b1; sbus.continuous = 1'b1;
    step();
    sbus.start = 1'b0; sbus.continuous = 1'b0;
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < N; i++) begin
        sbus.bit_valid = 1'b1; sbus.bit_in = 1'b0;
        step();
      end
      sbus.bit_valid = 1'b0;
      exp = (w + 1 > 3) ? 3 : w + 1;
      checks++; if (sbus.result_valid !== 1'b1) $display("FAIL sat%0d_rv: got %b want 1", w, sbus.result_valid); else passed++;
      checks++; if (sbus.fail_cnt !== 2'(exp)) $display("FAIL sat%0d_fail: got %0d want %0d", w, sbus.fail_cnt, exp); else passed++;
      step();
    end
    sbus.clear = 1'b1;
    step();
    sbus.clear = 1'b0;
    checks++; if (sbus.fail_cnt !== 2'd0) $display("FAIL sat_clear: got %0d want 0", sbus.fail_cnt); else passed++;
  endtask

  initial begin
    bus.start = 1'b0; bus.continuous = 1'b0; bus.clear = 1'b0;
    bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
    sbus.start = 1'b0; sbus.continuous = 1'b0; sbus.clear = 1'b0;
    sbus.bit_in = 1'b0; sbus.bit_valid = 1'b0;
    test_reset();
    test_balanced();
    test_threshold();
    test_clear_mid();
    test_continuous_gaps();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
